// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate backed by a word-organised memory, with configurable
// wait states, byte-lane writes and the two-cycle ERROR response.
module ahb_sub_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hselx,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hready,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hreadyout,
    output logic                    hresp
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = $clog2(BYTES);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state_q, state_d, start_state;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LANE_W-1:0]   off_q, off_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic                err_q, err_d;
    logic [2:0]          cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  can_accept;
    logic                  misalign;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [BYTES-1:0]      lane_mask;
    logic                  wr_en;
    logic                  unused_ok;

    assign unused_ok = ^{hburst, htrans[0], err_q};

    assign accept   = hselx && hready && htrans[1];
    assign word_idx = haddr >> LANE_W;

    // The three error sources are evaluated independently on the raw address phase.
    always_comb begin
        misalign = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (i < 32'(hsize) && haddr[i]) begin
                misalign = 1'b1;
            end
        end
    end

    assign addr_err = (word_idx >= ADDR_WIDTH'(MEM_DEPTH)) ||
                      (hsize > 3'(LANE_W)) || misalign;

    assign start_state = addr_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DONE);
    assign can_accept  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        off_d     = off_q;
        write_d   = write_q;
        size_d    = size_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;

        case (state_q)
            S_WAIT: begin
                hreadyout = 1'b0;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'(WAIT_STATES - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!write_q) begin
                    hrdata = mem[idx_q];
                end
                state_d = S_IDLE;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new address phase overrides the default return to IDLE.
        if (accept && can_accept) begin
            state_d = start_state;
            idx_d   = word_idx[IDX_W-1:0];
            off_d   = haddr[LANE_W-1:0];
            write_d = hwrite;
            size_d  = hsize;
            err_d   = addr_err;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            write_q <= write_d;
            size_q  <= size_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            lane_mask[b] = (b >= 32'(off_q)) && (b < 32'(off_q) + (32'd1 << size_q));
        end
    end

    assign wr_en = (state_q == S_DONE) && write_q && !hreset;

    always_ff @(posedge hclk) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (wr_en && hwstrb[b] && lane_mask[b]) begin
                mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Scoreboard bench for ahb_sub_mem: three instances with 0, 3 and 2 wait states,
// each driven by a pipelined AHB master and compared against a byte-lane memory model.
module tb_ahb_sub_mem;

    logic        hclk = 1'b0;
    logic        hreset    [3];
    logic        hselx     [3];
    logic [31:0] haddr     [3];
    logic [1:0]  htrans    [3];
    logic        hwrite    [3];
    logic [2:0]  hsize     [3];
    logic [2:0]  hburst    [3];
    logic [3:0]  hwstrb    [3];
    logic [31:0] hwdata    [3];
    logic        hready    [3];
    logic [31:0] hrdata    [3];
    logic        hreadyout [3];
    logic        hresp     [3];

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hready[g] = hreadyout[g];
        ahb_sub_mem #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_DEPTH  (256),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .hclk     (hclk),
            .hreset   (hreset[g]),
            .hselx    (hselx[g]),
            .haddr    (haddr[g]),
            .htrans   (htrans[g]),
            .hwrite   (hwrite[g]),
            .hsize    (hsize[g]),
            .hburst   (hburst[g]),
            .hwstrb   (hwstrb[g]),
            .hwdata   (hwdata[g]),
            .hready   (hready[g]),
            .hrdata   (hrdata[g]),
            .hreadyout(hreadyout[g]),
            .hresp    (hresp[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] rdata;
        int          lowc;
    } exp_t;

    xfer_t       tq  [$];
    exp_t        sbq [$];
    logic [31:0] mdl [3][256];

    function automatic logic model_err(input xfer_t x);
        logic [31:0] amask;
        amask = (32'd1 << x.size) - 32'd1;
        return ((x.addr >> 2) >= 32'd256) || (x.size > 3'd2) || ((x.addr & amask) != 32'd0);
    endfunction

    task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] d, input logic [3:0] st);
        xfer_t x;
        x.addr = a; x.wr = w; x.size = s; x.wdata = d; x.strb = st;
        tq.push_back(x);
    endtask

    task automatic idle_bus(input int k);
        hselx[k]  = 1'b0;
        htrans[k] = 2'd0;
        haddr[k]  = 32'($urandom);
        hwrite[k] = 1'($urandom);
        hsize[k]  = 3'd0;
        hburst[k] = 3'd0;
        hwstrb[k] = 4'($urandom);
        hwdata[k] = 32'($urandom);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_list(input int k, input int ws);
        xfer_t x;
        xfer_t cx;
        exp_t  e;
        bit    dp;
        int    low;
        int    guard;
        int    off;
        int    n;
        logic [7:0] widx;
        dp = 0; low = 0; guard = 0;
        cx = '{default: '0};
        while ((tq.size() > 0 || dp) && guard < 400) begin
            guard++;
            idle_bus(k);
            if (tq.size() > 0) begin
                x         = tq[0];
                hselx[k]  = 1'b1;
                htrans[k] = 2'd2;
                haddr[k]  = x.addr;
                hwrite[k] = x.wr;
                hsize[k]  = x.size;
                hburst[k] = 3'($urandom_range(0, 7));
            end
            if (dp && cx.wr) begin
                hwdata[k] = cx.wdata;
                hwstrb[k] = cx.strb;
            end
            @(negedge hclk);
            if (dp) begin
                if (!hreadyout[k]) begin
                    low++;
                    chk("wait_resp", 32'(hresp[k]), 32'(sbq[0].err));
                    chk("wait_rdata", hrdata[k], 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("low_cycles", 32'(low), 32'(e.lowc));
                    chk("resp", 32'(hresp[k]), 32'(e.err));
                    chk("rdata", hrdata[k], (e.wr || e.err) ? 32'd0 : e.rdata);
                    dp = 0;
                end
            end else begin
                chk("idle_ready", 32'(hreadyout[k]), 32'd1);
                chk("idle_resp", 32'(hresp[k]), 32'd0);
            end
            if (tq.size() > 0 && hreadyout[k]) begin
                x      = tq.pop_front();
                widx   = x.addr[9:2];
                e.err  = model_err(x);
                e.wr   = x.wr;
                e.lowc = e.err ? 1 : ws;
                e.rdata = mdl[k][widx];
                if (!e.err && x.wr) begin
                    off = int'(x.addr[1:0]);
                    n   = 1 << x.size;
                    for (int b = 0; b < 4; b++) begin
                        if (x.strb[b] && b >= off && b < off + n) begin
                            mdl[k][widx][8*b +: 8] = x.wdata[8*b +: 8];
                        end
                    end
                end
                sbq.push_back(e);
                cx  = x;
                dp  = 1;
                low = 0;
            end
            @(posedge hclk);
            #1;
        end
        if (guard >= 400) begin
            chk("timeout", 32'd1, 32'd0);
        end
        idle_bus(k);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            hreset[k] = 1'b1;
            idle_bus(k);
            for (int w = 0; w < 256; w++) mdl[k][w] = '0;
        end
        repeat (2) @(posedge hclk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 32'(hreadyout[k]), 32'd1);
            chk("reset_resp", 32'(hresp[k]), 32'd0);
            chk("reset_rdata", hrdata[k], 32'd0);
            hreset[k] = 1'b0;
        end

        // Zero-wait instance: pipelining, byte lanes, error responses, boundaries.
        push(32'h000, 1, 3'd2, 32'h11223344, 4'hF);
        push(32'h010, 1, 3'd2, 32'hDEADBEEF, 4'hF);
        push(32'h010, 0, 3'd2, 32'h0,        4'h0);
        push(32'h400, 1, 3'd2, 32'hFFFFFFFF, 4'hF);
        push(32'h000, 0, 3'd2, 32'h0,        4'h0);
        push(32'h010, 1, 3'd2, 32'h00000000, 4'hF);
        push(32'h012, 1, 3'd0, 32'h00AB0000, 4'hF);
        push(32'h010, 0, 3'd2, 32'h0,        4'h0);
        push(32'h011, 1, 3'd1, 32'hFFFFFFFF, 4'hF);
        push(32'h000, 1, 3'd3, 32'hFFFFFFFF, 4'hF);
        push(32'h000, 0, 3'd2, 32'h0,        4'h0);
        push(32'h002, 1, 3'd1, 32'hBEEF5566, 4'hF);
        push(32'h000, 1, 3'd1, 32'h7777AA99, 4'h1);
        push(32'h000, 0, 3'd2, 32'h0,        4'h0);
        push(32'h3FC, 1, 3'd2, 32'hA1B2C3D4, 4'hF);
        push(32'h3FC, 0, 3'd2, 32'h0,        4'h0);
        push(32'h3FD, 1, 3'd0, 32'h00005E00, 4'h2);
        push(32'h3FC, 0, 3'd2, 32'h0,        4'h0);
        run_list(0, 0);

        // Three-wait instance: wait count, and no wait before an error.
        push(32'h008, 1, 3'd2, 32'hA5A55A5A, 4'hF);
        push(32'h008, 0, 3'd2, 32'h0,        4'h0);
        push(32'h401, 1, 3'd0, 32'hFFFFFFFF, 4'hF);
        push(32'h00A, 1, 3'd1, 32'h3C3C0000, 4'hC);
        push(32'h008, 0, 3'd2, 32'h0,        4'h0);
        run_list(1, 3);

        // Two-wait instance: reset during the second wait cycle abandons the write.
        push(32'h020, 1, 3'd2, 32'hCAFEF00D, 4'hF);
        run_list(2, 2);
        hselx[2]  = 1'b1;
        htrans[2] = 2'd2;
        haddr[2]  = 32'h020;
        hwrite[2] = 1'b1;
        hsize[2]  = 3'd2;
        @(posedge hclk);
        #1;
        idle_bus(2);
        hwdata[2] = 32'h12345678;
        hwstrb[2] = 4'hF;
        @(negedge hclk);
        chk("rst_wait1_ready", 32'(hreadyout[2]), 32'd0);
        @(posedge hclk);
        #1;
        chk("rst_wait2_ready", 32'(hreadyout[2]), 32'd0);
        hreset[2] = 1'b1;
        @(posedge hclk);
        #1;
        chk("rst_mid_ready", 32'(hreadyout[2]), 32'd1);
        chk("rst_mid_resp", 32'(hresp[2]), 32'd0);
        chk("rst_mid_rdata", hrdata[2], 32'd0);
        hreset[2] = 1'b0;
        push(32'h020, 0, 3'd2, 32'h0, 4'h0);
        run_list(2, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
